// File: rtl/uart_tx_regs.sv
// Memory-mapped 8N1 UART transmitter: CTRL/STATUS/DIV/TXDATA registers,
// a 4-entry byte FIFO and a start/data/stop shift FSM driving tx_pin.
module uart_tx_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_pin
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic        tx_en;
    logic        ovf;
    logic [15:0] div_reg;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        avail_q;

    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [15:0] timer;
    logic [15:0] reload;

    logic        sel;
    logic [3:0]  offset;
    logic        wr_ctrl, wr_status, wr_div, wr_txdata;
    logic        full, empty, busy, push, pop;
    logic        unused_data;

    // Offsets at or above 0x10 inside the window are unmapped, not aliases.
    assign sel       = req_i && (addr_i[31:28] == BASE_ADDR[31:28])
                             && (addr_i[27:4] == BASE_ADDR[27:4]);
    assign offset    = addr_i[3:0];
    assign wr_ctrl   = sel && we_i && (offset == 4'h0);
    assign wr_status = sel && we_i && (offset == 4'h4);
    assign wr_div    = sel && we_i && (offset == 4'h8);
    assign wr_txdata = sel && we_i && (offset == 4'hC);

    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);
    assign busy  = !empty || (state != IDLE);
    assign push  = wr_txdata && !full;
    assign pop   = (state == IDLE) && tx_en && avail_q && !empty;

    assign unused_data = ^data_i[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en   <= 1'b0;
            div_reg <= DEFAULT_DIV;
            ovf     <= 1'b0;
        end else begin
            if (wr_ctrl)
                tx_en <= data_i[0];
            if (wr_div)
                div_reg <= (data_i[15:0] < 16'd2) ? 16'd2 : data_i[15:0];
            if (wr_txdata && full)
                ovf <= 1'b1;
            else if (wr_status && data_i[2])
                ovf <= 1'b0;
        end
    end

    // avail_q lags the occupancy by a cycle, giving a fresh byte one IDLE
    // evaluation cycle before its start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            avail_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= data_i[7:0];
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            avail_q <= !empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_pin  <= 1'b1;
            shift   <= 8'd0;
            bit_cnt <= 3'd0;
            timer   <= 16'd0;
            reload  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx_pin <= 1'b1;
                    if (pop) begin
                        shift   <= fifo_mem[rd_ptr];
                        reload  <= div_reg;
                        timer   <= div_reg - 16'd1;
                        bit_cnt <= 3'd0;
                        tx_pin  <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (timer == 16'd0) begin
                        timer  <= reload - 16'd1;
                        tx_pin <= shift[0];
                        state  <= DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (timer == 16'd0) begin
                        timer <= reload - 16'd1;
                        if (bit_cnt == 3'd7) begin
                            tx_pin <= 1'b1;
                            state  <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx_pin  <= shift[1];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                STOP: begin
                    if (timer == 16'd0) begin
                        tx_pin <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    tx_pin <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (sel && !we_i) begin
            case (offset)
                4'h0:    data_o = {31'd0, tx_en};
                4'h4:    data_o = {29'd0, ovf, full, busy};
                4'h8:    data_o = {16'd0, div_reg};
                default: data_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_regs.sv
// Scoreboard bench for uart_tx_regs: register reads and serial frames are
// queued as expectations by the stimulus and checked by independent monitors.
`timescale 1ns/1ps
module tb_uart_tx_regs;

    localparam logic [31:0] CTRL   = 32'h3000_0000;
    localparam logic [31:0] STATUS = 32'h3000_0004;
    localparam logic [31:0] DIVR   = 32'h3000_0008;
    localparam logic [31:0] TXDATA = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         gap;
    } frame_t;

    frame_t      frameq[$];
    logic [31:0] rdq[$];
    string       rdnameq[$];
    int          checks = 0;
    int          errors = 0;
    bit          frame_chk = 1'b0;
    bit          in_frame = 1'b0;

    frame_t      cur;
    int          cyc, idle_cnt, bad, bidx;
    logic        expbit;
    logic [7:0]  got;

    always #5 clk = ~clk;

    uart_tx_regs dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .we_i   (we),
        .addr_i (addr),
        .data_i (wdata),
        .data_o (rdata),
        .tx_pin (tx)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp, input string nm);
        @(posedge clk);
        #1;
        req = 1'b1;
        we = w;
        addr = a;
        wdata = d;
        if (!w) begin
            rdq.push_back(exp);
            rdnameq.push_back(nm);
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 32'd0, "");
    endtask

    task automatic busRead(input logic [31:0] a, input logic [31:0] exp, input string nm);
        applyStimulus(1'b0, a, 32'd0, exp, nm);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        req = 1'b0;
        we = 1'b0;
        if (n > 1) repeat (n - 1) @(posedge clk);
    endtask

    task automatic pushFrame(input logic [7:0] d, input int div, input int gap);
        frame_t f;
        f.data = d;
        f.div = div;
        f.gap = gap;
        frameq.push_back(f);
    endtask

    task automatic waitTxFall(output int n);
        idle(1);
        n = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                n = i;
                break;
            end
        end
        checkOutput("start bit seen", (n >= 0), 1'b1);
    endtask

    task automatic waitFramesDone(input int budget);
        bit done;
        idle(1);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frameq.size() == 0 && !in_frame) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("frames drained", done, 1'b1);
    endtask

    // Read scoreboard: every load presented to the DUT consumes one expectation.
    always @(negedge clk) begin
        if (!rst && req && !we) begin
            if (rdq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL read scoreboard: load at 0x%08h returned 0x%08h with nothing queued", addr, rdata);
            end else begin
                checkOutput(rdnameq.pop_front(), rdata, rdq.pop_front());
            end
        end
    end

    // Serial monitor: samples every cycle of a frame against the queued byte/divisor.
    always @(negedge clk) begin
        if (rst || !frame_chk) begin
            in_frame = 1'b0;
            idle_cnt = 0;
        end else begin
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    if (frameq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected frame: tx_pin went low with no frame queued, required idle high");
                        frame_chk = 1'b0;
                    end else begin
                        cur = frameq.pop_front();
                        if (cur.gap >= 0)
                            checkOutput("idle gap before frame", idle_cnt, cur.gap);
                        in_frame = 1'b1;
                        cyc = 0;
                        bad = 0;
                        got = 8'd0;
                    end
                end else begin
                    idle_cnt++;
                end
            end
            if (in_frame) begin
                bidx = cyc / cur.div;
                if (bidx == 0)
                    expbit = 1'b0;
                else if (bidx == 9)
                    expbit = 1'b1;
                else
                    expbit = cur.data[bidx - 1];
                if (tx !== expbit) bad++;
                if (bidx >= 1 && bidx <= 8 && (cyc % cur.div) == (cur.div / 2))
                    got[bidx - 1] = tx;
                cyc++;
                if (cyc == 10 * cur.div) begin
                    checkOutput($sformatf("frame byte 0x%02h", cur.data), got, cur.data);
                    checkOutput($sformatf("frame 0x%02h wrong samples", cur.data), bad, 0);
                    in_frame = 1'b0;
                    idle_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset defaults, then a reset that lands in the middle of a frame.
        busRead(STATUS, 32'h0, "STATUS reset");
        busRead(CTRL, 32'h0, "CTRL reset");
        busRead(DIVR, 32'd434, "DIV reset");
        busWrite(DIVR, 32'd4);
        busWrite(CTRL, 32'd1);
        busWrite(TXDATA, 32'h00);
        busWrite(TXDATA, 32'h00);
        waitTxFall(n);
        idle(6);
        @(negedge clk);
        checkOutput("tx_pin low mid-frame", tx, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("tx_pin at reset edge", tx, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        frame_chk = 1'b1;
        busRead(STATUS, 32'h0, "STATUS after reset");
        busRead(CTRL, 32'h0, "CTRL after reset");
        busRead(DIVR, 32'd434, "DIV after reset");
        idle(60);

        // Single frame 0xA5 at 4 cycles per bit; busy drops right after STOP.
        busWrite(DIVR, 32'd4);
        busWrite(CTRL, 32'd1);
        pushFrame(8'hA5, 4, -1);
        busWrite(TXDATA, 32'hA5);
        busRead(STATUS, 32'h1, "STATUS busy after store");
        waitTxFall(n);
        checkOutput("start latency", n, 1);
        repeat (38) @(posedge clk);
        busRead(STATUS, 32'h1, "STATUS in last stop cycle");
        busRead(STATUS, 32'h0, "STATUS after stop");
        waitFramesDone(50);

        // Back-to-back frames; DIV change lands mid-frame.
        busWrite(DIVR, 32'd3);
        pushFrame(8'h31, 3, -1);
        pushFrame(8'h32, 5, 1);
        busWrite(TXDATA, 32'h31);
        busWrite(TXDATA, 32'h32);
        busWrite(DIVR, 32'd5);
        busRead(DIVR, 32'd5, "DIV readback 5");
        waitFramesDone(300);

        // Overflow with transmitter disabled.
        busWrite(CTRL, 32'd0);
        busWrite(TXDATA, 32'h11);
        busWrite(TXDATA, 32'h22);
        busWrite(TXDATA, 32'h33);
        busWrite(TXDATA, 32'h44);
        busWrite(TXDATA, 32'h55);
        busRead(STATUS, 32'h7, "STATUS after overflow");
        busWrite(STATUS, 32'h4);
        busRead(STATUS, 32'h3, "STATUS after W1C");
        pushFrame(8'h11, 5, -1);
        pushFrame(8'h22, 5, 1);
        pushFrame(8'h33, 5, 1);
        pushFrame(8'h44, 5, 1);
        busWrite(CTRL, 32'd1);
        waitFramesDone(400);
        busRead(STATUS, 32'h0, "STATUS after drain");

        // Disabling mid-frame finishes the frame and holds the next byte.
        busWrite(DIVR, 32'd3);
        pushFrame(8'hC3, 3, -1);
        busWrite(TXDATA, 32'hC3);
        busWrite(TXDATA, 32'h3C);
        waitTxFall(n);
        idle(8);
        busWrite(CTRL, 32'd0);
        idle(60);
        busRead(STATUS, 32'h1, "STATUS held byte");
        busRead(CTRL, 32'h0, "CTRL cleared");
        pushFrame(8'h3C, 3, -1);
        busWrite(CTRL, 32'd1);
        waitFramesDone(100);
        busRead(STATUS, 32'h0, "STATUS after gated drain");

        // Decode edges.
        busWrite(DIVR, 32'd0);
        busRead(DIVR, 32'd2, "DIV write 0 clamps");
        busWrite(DIVR, 32'd1);
        busRead(DIVR, 32'd2, "DIV write 1 clamps");
        busRead(32'h3000_0010, 32'h0, "offset 0x10 read");
        busRead(TXDATA, 32'h0, "TXDATA read");
        busWrite(32'h2000_000C, 32'h77);
        busRead(STATUS, 32'h0, "STATUS after out-of-window store");
        busWrite(32'h3000_0010, 32'h0);
        busRead(CTRL, 32'h1, "CTRL after offset 0x10 store");
        busRead(32'h2000_0000, 32'h0, "out-of-window read");
        idle(40);

        checkOutput("frames outstanding", frameq.size(), 0);
        checkOutput("reads outstanding", rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
